// File: rtl/fetch_pc_predictor_if.sv
// -----------------------------------------------------------------------------
// fetch_pc_predictor_if
//
// Bundles the fetch-side and resolve-side signals of the fetch PC predictor.
//
//   Fetch side
//     stall           : hold the current fetch PC (hazard stall)
//     pc_out          : current fetch PC
//     pred_taken      : prediction for the instruction at pc_out
//     pred_target     : predicted target (zero unless pred_taken)
//
//   Resolve side (from the ID-stage branch comparator)
//     res_valid       : a resolved instruction is presented this cycle
//     res_branch      : that instruction is a conditional branch
//     res_taken       : comparator outcome (branch && operands equal)
//     res_pc          : PC of the resolved instruction
//     res_target      : computed branch target
//     res_pred_taken  : prediction that travelled with the instruction
//     res_pred_target : predicted target that travelled with it
//     flush           : squash IF/ID this cycle (misprediction)
//
// Modports
//   slave  : the predictor itself
//   master : the surrounding pipeline that drives stall/resolution
// -----------------------------------------------------------------------------
interface fetch_pc_predictor_if #(
   parameter int unsigned N = 32
);

   logic         stall;
   logic [N-1:0] pc_out;
   logic         pred_taken;
   logic [N-1:0] pred_target;

   logic         res_valid;
   logic         res_branch;
   logic         res_taken;
   logic [N-1:0] res_pc;
   logic [N-1:0] res_target;
   logic         res_pred_taken;
   logic [N-1:0] res_pred_target;
   logic         flush;

   modport slave (
      input  stall,
      input  res_valid,
      input  res_branch,
      input  res_taken,
      input  res_pc,
      input  res_target,
      input  res_pred_taken,
      input  res_pred_target,
      output pc_out,
      output pred_taken,
      output pred_target,
      output flush
   );

   modport master (
      output stall,
      output res_valid,
      output res_branch,
      output res_taken,
      output res_pc,
      output res_target,
      output res_pred_taken,
      output res_pred_target,
      input  pc_out,
      input  pred_taken,
      input  pred_target,
      input  flush
   );

endinterface

// File: rtl/fetch_pc_predictor.sv
// -----------------------------------------------------------------------------
// fetch_pc_predictor
//
// Fetch-stage PC generator with a direct-mapped branch history table of 2-bit
// saturating counters and a branch target buffer sharing the same index.
// Each cycle it predicts the next fetch PC from the entry selected by pc_out;
// resolved branches from the ID-stage comparator train the tables, and a
// misprediction redirects the PC on the next edge while raising flush in the
// same cycle the resolution is presented.
//
// Parameters
//   N        : PC / data width in bits
//   M        : number of table entries (power of two, >= 2)
//   RESET_PC : PC loaded on reset
//
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset (clears all history)
//   bus  : fetch_pc_predictor_if.slave (fetch and resolve signals)
//
// Address split: index = pc[IDX+1:2], tag = pc[N-1:IDX+2], bits [1:0] ignored.
// -----------------------------------------------------------------------------
module fetch_pc_predictor #(
   parameter int unsigned   N        = 32,
   parameter int unsigned   M        = 16,
   parameter logic [N-1:0]  RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   fetch_pc_predictor_if.slave bus
);

   // --------------------------------------------------------------------------
   // Local types and constants
   // --------------------------------------------------------------------------
   localparam int unsigned IDX   = $clog2(M);
   localparam int unsigned TAG_W = N - IDX - 2;

   typedef logic [IDX-1:0]   idx_t;
   typedef logic [TAG_W-1:0] tag_t;
   typedef logic [1:0]       ctr_t;

   localparam logic [N-1:0] PC_STEP     = N'(4);
   localparam ctr_t         CTR_MIN     = 2'b00;
   localparam ctr_t         CTR_WEAK_NT = 2'b01;
   localparam ctr_t         CTR_MAX     = 2'b11;

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   logic [N-1:0] pc_q;
   logic [N-1:0] pc_next;

   logic         valid_q  [M];
   tag_t         tag_q    [M];
   logic [N-1:0] target_q [M];
   ctr_t         ctr_q    [M];

   // --------------------------------------------------------------------------
   // Address decomposition
   // --------------------------------------------------------------------------
   idx_t fetch_idx;
   tag_t fetch_tag;
   idx_t res_idx;
   tag_t res_tag;

   assign fetch_idx = bus.pc_out[IDX+1:2];
   assign fetch_tag = bus.pc_out[N-1:IDX+2];
   assign res_idx   = bus.res_pc[IDX+1:2];
   assign res_tag   = bus.res_pc[N-1:IDX+2];

   // --------------------------------------------------------------------------
   // Lookup on the current fetch PC. Reads the registered tables, so a
   // training write to the same index this cycle is seen only next cycle.
   // --------------------------------------------------------------------------
   logic         hit;
   logic         pred_taken;
   logic [N-1:0] pred_target;

   assign hit         = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
   assign pred_taken  = hit && ctr_q[fetch_idx][1];
   assign pred_target = pred_taken ? target_q[fetch_idx] : '0;

   // --------------------------------------------------------------------------
   // Misprediction detect. A taken branch is also wrong when the target it
   // was fetched with differs from the computed one.
   // --------------------------------------------------------------------------
   logic train;
   logic mis;

   assign train = bus.res_valid && bus.res_branch;
   assign mis   = train &&
                  ((bus.res_taken != bus.res_pred_taken) ||
                   (bus.res_taken && (bus.res_pred_target != bus.res_target)));

   // --------------------------------------------------------------------------
   // Next-PC selection (reset is applied in the register below, above all).
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: default first so every path assigns pc_next and no latch forms.
      pc_next = pc_q + PC_STEP;
      if (mis) begin
         pc_next = bus.res_taken ? bus.res_target : (bus.res_pc + PC_STEP);
      end else if (bus.stall) begin
         pc_next = pc_q;
      end else if (pred_taken) begin
         pc_next = pred_target;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_next;
      end
   end

   // --------------------------------------------------------------------------
   // Counter training: saturating increment on taken, decrement otherwise.
   // --------------------------------------------------------------------------
   ctr_t ctr_cur;
   ctr_t ctr_next;

   assign ctr_cur = ctr_q[res_idx];

   always_comb begin
      ctr_next = ctr_cur;
      if (bus.res_taken) begin
         if (ctr_cur != CTR_MAX) begin
            ctr_next = ctr_cur + 2'd1;
         end
      end else begin
         if (ctr_cur != CTR_MIN) begin
            ctr_next = ctr_cur - 2'd1;
         end
      end
   end

   // NOTE: only valid bits and counters are reset; tag and target storage is
   // meaningless while valid=0, so it is left unreset and kept in a separate
   // process that maps onto plain RAM/flops without a reset network.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '{default: 1'b0};
         ctr_q   <= '{default: CTR_WEAK_NT};
      end else if (train) begin
         ctr_q[res_idx] <= ctr_next;
         if (bus.res_taken) begin
            valid_q[res_idx] <= 1'b1;
         end
      end
   end

   // A taken branch claims the entry outright, replacing any aliasing owner;
   // the counter is kept and updated in place rather than reinitialised.
   always_ff @(posedge clk) begin
      if (!rst && train && bus.res_taken) begin
         tag_q[res_idx]    <= res_tag;
         target_q[res_idx] <= bus.res_target;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign bus.pc_out      = pc_q;
   assign bus.pred_taken  = pred_taken;
   assign bus.pred_target = pred_target;
   assign bus.flush       = mis && !rst;

endmodule

// File: tb/tb_fetch_pc_predictor.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_predictor
//
// Directed scenarios followed by a randomized run. Expected values come from
// constants for the directed cases and from a table-level reference model
// (arrays of entries, integer counters, integer index/tag arithmetic) that is
// advanced alongside the design every clock.
// -----------------------------------------------------------------------------
module tb_fetch_pc_predictor;

   localparam logic [31:0] RESET_PC = 32'h0000_0100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fetch_pc_predictor_if #(.N(32)) bus ();

   fetch_pc_predictor #(
      .N        (32),
      .M        (16),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // --------------------------------------------------------------------------
   // Reference model: one record per table slot
   // --------------------------------------------------------------------------
   bit          m_valid  [16];
   logic [31:0] m_tag    [16];
   logic [31:0] m_target [16];
   int          m_ctr    [16];
   logic [31:0] m_pc = RESET_PC;

   function automatic int slot_of(input logic [31:0] pc);
      return int'((pc / 4) % 16);
   endfunction

   function automatic bit m_pt(input logic [31:0] pc);
      int s = slot_of(pc);
      return m_valid[s] && (m_tag[s] == pc / 64) && (m_ctr[s] >= 2);
   endfunction

   function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
      return m_pt(pc) ? m_target[slot_of(pc)] : 32'h0;
   endfunction

   function automatic bit m_mis();
      if (!(bus.res_valid && bus.res_branch)) return 1'b0;
      if (bus.res_taken != bus.res_pred_taken) return 1'b1;
      return bus.res_taken && (bus.res_pred_target != bus.res_target);
   endfunction

   // Drive inputs just after an edge and let combinational outputs settle.
   task automatic drive(input logic s, v, b, t, input logic [31:0] p, tg,
                        input logic pt, input logic [31:0] ptg);
      bus.stall           = s;
      bus.res_valid       = v;
      bus.res_branch      = b;
      bus.res_taken       = t;
      bus.res_pc          = p;
      bus.res_target      = tg;
      bus.res_pred_taken  = pt;
      bus.res_pred_target = ptg;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
   endtask

   // Advance one clock, applying the same edge to the model.
   task automatic tick();
      logic [31:0] npc;
      int          s;
      if (rst)                  npc = RESET_PC;
      else if (m_mis())         npc = bus.res_taken ? bus.res_target : bus.res_pc + 32'd4;
      else if (bus.stall)       npc = m_pc;
      else if (m_pt(m_pc))      npc = m_ptgt(m_pc);
      else                      npc = m_pc + 32'd4;
      @(posedge clk);
      m_pc = npc;
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
         end
      end else if (bus.res_valid && bus.res_branch) begin
         s = slot_of(bus.res_pc);
         if (bus.res_taken) begin
            m_ctr[s]    = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
            m_valid[s]  = 1'b1;
            m_tag[s]    = bus.res_pc / 64;
            m_target[s] = bus.res_target;
         end else begin
            m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
         end
      end
      #1;
   endtask

   // Force fetch to tgt with a guaranteed mispredict from an unrelated PC.
   task automatic redirect(input logic [31:0] tgt);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_07F0, tgt, 1'b0, 32'h0);
      tick();
      idle();
   endtask

   // --------------------------------------------------------------------------
   // Scenarios
   // --------------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h104, 32'h200, 1'b0, 32'h0);
      tick();
      if (bus.pc_out !== RESET_PC) begin errors++; $display("FAIL reset_pc got %h want %h", bus.pc_out, RESET_PC); end
      checks++;
      if (bus.flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b want 0", bus.flush); end
      checks++;
      if (bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h0) begin
         errors++; $display("FAIL reset_pred got %b/%h want 0/0", bus.pred_taken, bus.pred_target);
      end
      checks++;
      rst = 1'b0;
      idle();
      for (int k = 1; k <= 3; k++) begin
         tick();
         if (bus.pc_out !== RESET_PC + 32'(4 * k) || bus.pred_taken !== 1'b0 || bus.flush !== 1'b0) begin
            errors++;
            $display("FAIL seq_pc step %0d got %h/%b/%b want %h/0/0", k, bus.pc_out, bus.pred_taken,
                     bus.flush, RESET_PC + 32'(4 * k));
         end
         checks++;
      end
   endtask

   task automatic test_mispredict_taken();
      drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h104, 32'h200, 1'b0, 32'h0);
      if (bus.flush !== 1'b1) begin errors++; $display("FAIL mis_flush got %b want 1", bus.flush); end
      checks++;
      tick();
      idle();
      if (bus.pc_out !== 32'h200) begin errors++; $display("FAIL mis_redirect got %h want 200", bus.pc_out); end
      checks++;
      redirect(32'h104);
      if (bus.pc_out !== 32'h104 || bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h200) begin
         errors++; $display("FAIL learned_pred got %h/%b/%h want 104/1/200", bus.pc_out, bus.pred_taken, bus.pred_target);
      end
      checks++;
      tick();
      if (bus.pc_out !== 32'h200) begin errors++; $display("FAIL follow_pred got %h want 200", bus.pc_out); end
      checks++;
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h104, 32'h200, 1'b1, 32'h200);
         if (bus.flush !== 1'b0) begin errors++; $display("FAIL correct_pred_flush %0d got %b want 0", k, bus.flush); end
         checks++;
         tick();
      end
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h104, 32'h200, 1'b1, 32'h200);
      if (bus.flush !== 1'b1) begin errors++; $display("FAIL nt_flush got %b want 1", bus.flush); end
      checks++;
      tick();
      idle();
      if (bus.pc_out !== 32'h108) begin errors++; $display("FAIL nt_redirect got %h want 108", bus.pc_out); end
      checks++;
      redirect(32'h104);
      if (bus.pred_taken !== 1'b1 || bus.pred_target !== 32'h200) begin
         errors++; $display("FAIL sat_still_taken got %b/%h want 1/200", bus.pred_taken, bus.pred_target);
      end
      checks++;
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h104, 32'h200, 1'b1, 32'h200);
      tick();
      redirect(32'h104);
      if (bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h0) begin
         errors++; $display("FAIL weak_nt_pred got %b/%h want 0/0", bus.pred_taken, bus.pred_target);
      end
      checks++;
   endtask

   task automatic test_stall_redirect();
      redirect(32'h300);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
      tick();
      if (bus.pc_out !== 32'h300) begin errors++; $display("FAIL stall_hold got %h want 300", bus.pc_out); end
      checks++;
      // Wrong predicted target on a taken branch, presented while stalled.
      drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h2F0, 32'h400, 1'b1, 32'h500);
      if (bus.flush !== 1'b1 || bus.pc_out !== 32'h300) begin
         errors++; $display("FAIL stall_mis got %b/%h want 1/300", bus.flush, bus.pc_out);
      end
      checks++;
      tick();
      idle();
      if (bus.pc_out !== 32'h400) begin errors++; $display("FAIL stall_redirect got %h want 400", bus.pc_out); end
      checks++;
   endtask

   task automatic test_non_branch();
      drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h104, 32'h900, 1'b0, 32'h0);
      if (bus.flush !== 1'b0) begin errors++; $display("FAIL nonbr_flush got %b want 0", bus.flush); end
      checks++;
      tick();
      idle();
      if (bus.pc_out !== 32'h404) begin errors++; $display("FAIL nonbr_advance got %h want 404", bus.pc_out); end
      checks++;
      redirect(32'h104);
      if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL nonbr_no_train got %b want 0", bus.pred_taken); end
      checks++;
   endtask

   task automatic test_reset_midrun();
      for (int k = 0; k < 2; k++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h104, 32'h200, 1'b0, 32'h0);
         tick();
      end
      redirect(32'h104);
      if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL pre_reset_pred got %b want 1", bus.pred_taken); end
      checks++;
      rst = 1'b1;
      idle();
      tick();
      rst = 1'b0;
      #1;
      if (bus.pc_out !== RESET_PC) begin errors++; $display("FAIL midrun_reset_pc got %h want %h", bus.pc_out, RESET_PC); end
      checks++;
      redirect(32'h104);
      if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL history_cleared got %b want 0", bus.pred_taken); end
      checks++;
      redirect(32'hFFFF_FFFC);
      if (bus.pc_out !== 32'hFFFF_FFFC || bus.pred_taken !== 1'b0) begin
         errors++; $display("FAIL wrap_setup got %h/%b want fffffffc/0", bus.pc_out, bus.pred_taken);
      end
      checks++;
      tick();
      if (bus.pc_out !== 32'h0) begin errors++; $display("FAIL pc_wrap got %h want 00000000", bus.pc_out); end
      checks++;
   endtask

   task automatic test_random();
      logic        s, v, b, t, pt;
      logic [31:0] p, tg, ptg;
      bit          exp_flush;
      for (int c = 0; c < 600; c++) begin
         rst = ($urandom_range(0, 59) == 0);
         s   = ($urandom_range(0, 3) == 0);
         v   = ($urandom_range(0, 1) == 1);
         b   = ($urandom_range(0, 9) < 7);
         t   = ($urandom_range(0, 1) == 1);
         p   = ($urandom_range(0, 3) == 0 ? 32'h0000_1100 : RESET_PC) + 32'($urandom_range(0, 15) * 4);
         tg  = RESET_PC + 32'($urandom_range(0, 31) * 4);
         pt  = ($urandom_range(0, 3) != 0) ? m_pt(p) : 1'($urandom_range(0, 1));
         ptg = ($urandom_range(0, 3) != 0) ? (m_pt(p) ? m_ptgt(p) : tg) : RESET_PC + 32'($urandom_range(0, 31) * 4);
         drive(s, v, b, t, p, tg, pt, ptg);
         exp_flush = m_mis() && !rst;
         if (bus.pc_out !== m_pc) begin
            errors++; $display("FAIL rand_pc cyc %0d got %h want %h", c, bus.pc_out, m_pc);
         end
         checks++;
         if (bus.pred_taken !== m_pt(m_pc) || bus.pred_target !== m_ptgt(m_pc)) begin
            errors++; $display("FAIL rand_pred cyc %0d got %b/%h want %b/%h", c, bus.pred_taken,
                               bus.pred_target, m_pt(m_pc), m_ptgt(m_pc));
         end
         checks++;
         if (bus.flush !== exp_flush) begin
            errors++; $display("FAIL rand_flush cyc %0d got %b want %b", c, bus.flush, exp_flush);
         end
         checks++;
         tick();
      end
      rst = 1'b0;
   endtask

   initial begin
      idle();
      test_reset();
      test_mispredict_taken();
      test_saturation();
      test_stall_redirect();
      test_non_branch();
      test_reset_midrun();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_pc_predictor.md
Name: fetch_pc_predictor

Overview:
Fetch-stage PC generator with a direct-mapped branch history table (BHT) of 2-bit saturating counters and a branch target buffer (BTB).
- Sits directly upstream of the ID-stage branch equality comparator.
- Predicts the next PC each cycle.
- Consumes the comparator's resolved outcome (branch AND operands equal) to train the tables.
- On misprediction, redirects the PC and raises a flush.

Parameters:
N, 32, PC/data width in bits.
M, 16, BHT/BTB entries; power of two, ≥2; IDX = log2(M).
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
stall  input  1  hold pc_out (hazard stall).
pc_out  output  N  current fetch PC.
pred_taken  output  1  prediction for instruction at pc_out.
pred_target  output  N  predicted target for pc_out (valid when pred_taken=1).
res_valid  input  1  ID stage presents a resolved instruction this cycle.
res_branch  input  1  resolved instruction is a conditional branch.
res_taken  input  1  comparator result (branch && data1==data2).
res_pc  input  N  PC of resolved instruction.
res_target  input  N  computed branch target.
res_pred_taken  input  1  pred_taken carried down the pipe with that instruction.
res_pred_target  input  N  pred_target carried down the pipe.
flush  output  1  squash IF/ID contents this cycle.

Behaviour:
- Index = pc[IDX+1:2]; tag = pc[N-1:IDX+2]. Bits [1:0] are ignored.
- Each entry holds: valid (1b), tag, target (N), counter (2b).

Reset (rst=1 at a clk edge):
- pc_out=RESET_PC.
- All valid=0, all counters=2'b01 (weakly not-taken).
- Consequently pred_taken=0, pred_target=0 and flush=0 while in reset.
- Reset mid-operation discards all history; rst overrides stall and redirect.

Lookup (combinational on pc_out):
- hit = valid[idx] && tag[idx]==pc_out tag.
- pred_taken = hit && counter[idx][1].
- pred_target = target[idx] when pred_taken, else 0.

Mispredict detect (combinational):
- mis = res_valid && res_branch && (res_taken != res_pred_taken || (res_taken && res_pred_target != res_target)).
- flush = mis. It is asserted in the same cycle the resolution is presented.
- res_valid with res_branch=0 never flushes and never trains.

Next PC, in priority order:
- rst → RESET_PC.
- mis → res_taken ? res_target : res_pc+4.
- stall → hold pc_out.
- pred_taken → pred_target.
- otherwise → pc_out+4.

Next-PC rules:
- Redirect overrides stall.
- Latency: one clock edge from mis to corrected pc_out.
- Addition is modulo 2^N: 0xFFFFFFFC+4 → 0x00000000.

Training (clk edge, when res_valid && res_branch):
- Counter at res_pc index: saturating +1 if res_taken (max 2'b11), −1 otherwise (min 2'b00).
- If res_taken: write valid=1, tag=res_pc tag, target=res_target. This replaces any aliasing entry; the counter is updated in place, not reset.
- Not-taken branches never modify tag, target or valid.

Simultaneous events:
- Lookup and training hit the same index in one cycle → lookup uses the pre-update values; the new values are visible from the next cycle.
- Training still occurs while stall=1.

Test Plan:
1. Reset with RESET_PC=0x100, then 3 cycles with no resolutions → pc_out 0x100, 0x104, 0x108, 0x10C; pred_taken=0, flush=0.
2. Resolve res_pc=0x104, res_taken=1, res_target=0x200, res_pred_taken=0 → flush=1 that cycle; next pc_out=0x200; entry 1 valid, counter 2'b10; a later fetch of 0x104 gives pred_taken=1, pred_target=0x200.
3. Train 0x104 taken three more times, then not-taken once with res_pred_taken=1 → counter saturates at 2'b11 then drops to 2'b10; flush=1; next pc_out=0x108; the next fetch of 0x104 still predicts taken.
4. stall=1 for 2 cycles at pc_out=0x300 with a mispredict (correct target 0x400) on the second cycle → pc_out holds 0x300, then becomes 0x400.
5. res_valid=1, res_branch=0 with res_taken=1 → flush=0; tables unchanged; pc_out advances by 4.
6. Assert rst mid-run after training entry 1 → pc_out=RESET_PC; fetching 0x104 gives pred_taken=0. Also pc_out=0xFFFFFFFC with no prediction → next pc_out=0x00000000.
